aes_key_expand_seq: RTL and testbench

//  Sequential AES-128 key expansion engine. Feeds the round datapath one 128-bit round key per handshake.

---
 rtl/aes_key_expand_if.sv | 22 ++
 rtl/aes_key_expand_seq.sv | 167 ++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// Round-key handshake bundle between the key expander and the round datapath.
// The master side starts an expansion and consumes round keys.
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_out, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_out, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: one round key per valid/ready transfer.
// Includes the byte S-box and round-constant table it depends on.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ t;
      t = xtime(t);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  always_comb begin
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    inv = r;
  end

  assign y = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
           ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
endmodule

module aes_rcon (
  input  logic [3:0]  select_i,
  output logic [31:0] rcon_o
);
  always_comb begin
    rcon_o = 32'h0;
    unique case (select_i)
      4'd1:    rcon_o = 32'h01000000;
      4'd2:    rcon_o = 32'h02000000;
      4'd3:    rcon_o = 32'h04000000;
      4'd4:    rcon_o = 32'h08000000;
      4'd5:    rcon_o = 32'h10000000;
      4'd6:    rcon_o = 32'h20000000;
      4'd7:    rcon_o = 32'h40000000;
      4'd8:    rcon_o = 32'h80000000;
      4'd9:    rcon_o = 32'h1b000000;
      4'd10:   rcon_o = 32'h36000000;
      default: rcon_o = 32'h0;
    endcase
  end
endmodule

module aes_key_expand_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input logic            clk,
  input logic            rst,
  aes_key_expand_if.slave kx
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_d;
  logic [127:0] key_reg, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         valid_c, busy_c;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, temp, rcon;
  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   rcon_sel;
  logic [127:0] next_key;

  assign {w0, w1, w2, w3} = key_reg;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  // Hold the select in 1..10 even while the last key is on the bus.
  assign rcon_sel = (round_q >= LAST) ? LAST : round_q + 4'd1;

  aes_rcon u_rcon (
    .select_i (rcon_sel),
    .rcon_o   (rcon)
  );

  assign temp     = sub ^ rcon;
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      key_reg <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    key_d   = key_reg;
    round_d = round_q;
    done_d  = 1'b0;
    valid_c = 1'b0;
    busy_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (kx.start) begin
          key_d   = kx.key_in;
          round_d = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        valid_c = 1'b1;
        busy_c  = 1'b1;
        if (kx.rk_ready) begin
          if (round_q < LAST) begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kx.rk_out   = key_reg;
  assign kx.rk_round = round_q;
  assign kx.rk_valid = valid_c;
  assign kx.busy     = busy_c;
  assign kx.done     = done_q;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for the sequential AES-128 key expander.
// Expected round keys are the published FIPS-197 values.
module tb_aes_key_expand_seq;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nbad = 0;

  aes_key_expand_if bus ();

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .kx  (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZKEY = 128'h0;

  logic [127:0] fexp [0:10];
  logic [127:0] zexp [0:2];

  initial begin
    fexp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fexp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fexp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fexp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fexp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fexp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fexp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fexp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fexp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fexp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fexp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zexp[0]  = 128'h0;
    zexp[1]  = 128'h62636363626363636263636362636363;
    zexp[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rk_ready = 1'b1;
    while (bus.rk_valid && n < 40) begin
      step();
      n++;
    end
    nvec++;
    if (bus.rk_valid !== 1'b0) begin
      nbad++;
      $display("FAIL drain_timeout rk_valid=%0b want 0", bus.rk_valid);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
    step();
    step();
    nvec++;
    if ({bus.rk_out, bus.rk_round, bus.rk_valid, bus.busy, bus.done} !== '0) begin
      nbad++;
      $display("FAIL reset_outputs got out=%h rnd=%0d v=%b b=%b d=%b want all 0",
               bus.rk_out, bus.rk_round, bus.rk_valid, bus.busy, bus.done);
    end
    rst = 1'b0;
    bus.rk_ready = 1'b1;
    step();
    nvec++;
    if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      nbad++;
      $display("FAIL idle_ready_ignored v=%b b=%b want 0 0", bus.rk_valid, bus.busy);
    end
  endtask

  task automatic test_fips_stream();
    bus.key_in = FKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    bus.key_in = ~FKEY;
    for (int k = 0; k <= 10; k++) begin
      nvec++;
      if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.rk_round !== 4'(k)
          || bus.rk_out !== fexp[k]) begin
        nbad++;
        $display("FAIL fips_round%0d got v=%b rnd=%0d out=%h want v=1 rnd=%0d out=%h",
                 k, bus.rk_valid, bus.rk_round, bus.rk_out, k, fexp[k]);
      end
      step();
    end
    nvec++;
    if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0
        || bus.rk_out !== fexp[10] || bus.rk_round !== 4'd10) begin
      nbad++;
      $display("FAIL fips_done got d=%b v=%b b=%b rnd=%0d want d=1 v=0 b=0 rnd=10",
               bus.done, bus.rk_valid, bus.busy, bus.rk_round);
    end
    step();
    nvec++;
    if (bus.done !== 1'b0) begin
      nbad++;
      $display("FAIL done_pulse_width got d=%b want 0", bus.done);
    end
  endtask

  task automatic test_zero_key();
    bus.key_in = ZKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      nvec++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(k) || bus.rk_out !== zexp[k]) begin
        nbad++;
        $display("FAIL zero_round%0d got rnd=%0d out=%h want rnd=%0d out=%h",
                 k, bus.rk_round, bus.rk_out, k, zexp[k]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_throttle();
    int idx;
    int cyc;
    logic rdy;
    idx = 0;
    cyc = 0;
    bus.key_in = FKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b0;
    step();
    bus.start = 1'b0;
    while (idx <= 10 && cyc < 300) begin
      nvec++;
      if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'(idx) || bus.rk_out !== fexp[idx]) begin
        nbad++;
        $display("FAIL throttle_round%0d got v=%b rnd=%0d out=%h want v=1 rnd=%0d out=%h",
                 idx, bus.rk_valid, bus.rk_round, bus.rk_out, idx, fexp[idx]);
      end
      rdy = ($urandom_range(0, 2) == 0);
      bus.rk_ready = rdy;
      step();
      if (rdy) idx++;
      cyc++;
    end
    nvec++;
    if (idx != 11 || bus.done !== 1'b1) begin
      nbad++;
      $display("FAIL throttle_end got idx=%0d d=%b want 11 1", idx, bus.done);
    end
    bus.rk_ready = 1'b0;
    step();
  endtask

  task automatic test_start_ignored();
    bus.key_in = FKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      nvec++;
      if (bus.rk_round !== 4'(k) || bus.rk_out !== fexp[k]) begin
        nbad++;
        $display("FAIL busy_start_round%0d got rnd=%0d out=%h want rnd=%0d out=%h",
                 k, bus.rk_round, bus.rk_out, k, fexp[k]);
      end
      bus.start = (k == 5);
      bus.key_in = (k == 5) ? ZKEY : FKEY;
      step();
    end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.key_in = ZKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bus.rk_ready = 1'b0;
    step();
    step();
    nvec++;
    if (bus.rk_round !== 4'd4 || bus.rk_valid !== 1'b1) begin
      nbad++;
      $display("FAIL stall_round4 got rnd=%0d v=%b want 4 1", bus.rk_round, bus.rk_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if ({bus.rk_out, bus.rk_round, bus.rk_valid, bus.busy, bus.done} !== '0) begin
      nbad++;
      $display("FAIL midreset_outputs got out=%h rnd=%0d v=%b b=%b d=%b want all 0",
               bus.rk_out, bus.rk_round, bus.rk_valid, bus.busy, bus.done);
    end
    step();
    nvec++;
    if (bus.rk_valid !== 1'b0) begin
      nbad++;
      $display("FAIL midreset_no_partial got v=%b want 0", bus.rk_valid);
    end
    bus.key_in = FKEY;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.rk_ready = 1'b1;
    nvec++;
    if (bus.rk_valid !== 1'b1 || bus.rk_round !== 4'd0 || bus.rk_out !== fexp[0]) begin
      nbad++;
      $display("FAIL postreset_round0 got v=%b rnd=%0d out=%h want 1 0 %h",
               bus.rk_valid, bus.rk_round, bus.rk_out, fexp[0]);
    end
    step();
    nvec++;
    if (bus.rk_round !== 4'd1 || bus.rk_out !== fexp[1]) begin
      nbad++;
      $display("FAIL postreset_round1 got rnd=%0d out=%h want 1 %h",
               bus.rk_round, bus.rk_out, fexp[1]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.key_in = FKEY;
    bus.start = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    nvec++;
    if (bus.rk_round !== 4'd10 || bus.rk_out !== fexp[10]) begin
      nbad++;
      $display("FAIL b2b_round10 got rnd=%0d out=%h want 10 %h",
               bus.rk_round, bus.rk_out, fexp[10]);
    end
    bus.key_in = ZKEY;
    bus.start = 1'b1;
    step();
    step();
    bus.start = 1'b0;
    nvec++;
    if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0
        || bus.rk_round !== 4'd0 || bus.rk_out !== zexp[0]) begin
      nbad++;
      $display("FAIL b2b_restart got v=%b b=%b d=%b rnd=%0d out=%h want 1 1 0 0 0",
               bus.rk_valid, bus.busy, bus.done, bus.rk_round, bus.rk_out);
    end
    step();
    nvec++;
    if (bus.rk_round !== 4'd1 || bus.rk_out !== zexp[1]) begin
      nbad++;
      $display("FAIL b2b_round1 got rnd=%0d out=%h want 1 %h",
               bus.rk_round, bus.rk_out, zexp[1]);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fips_stream();
    test_zero_key();
    test_throttle();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
